// File: rtl/clock_alarm_core.sv
// BCD time-of-day clock with programmable alarm, snooze and 12/24-hour display.
// Hours are kept internally as 0-23 and converted to the selected format at the display registers.
module clock_alarm_core #(
    parameter int REFERENCE_CLOCK = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int HOUR_MODE       = 24,
    parameter int ALARM_HR_INIT   = 6,
    parameter int ALARM_MIN_INIT  = 0,
    parameter int SNOOZE_MIN      = 5,
    parameter int RING_SECONDS    = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       set_clock,
    input  logic       set_alarm,
    input  logic       min_inc,
    input  logic       hr_inc,
    input  logic       alarm_en,
    input  logic       alarm_off,
    input  logic       snooze,
    output logic [3:0] sec_u,
    output logic [2:0] sec_t,
    output logic [3:0] min_u,
    output logic [2:0] min_t,
    output logic [3:0] hr_u,
    output logic [1:0] hr_t,
    output logic       pm,
    output logic       alarm_out,
    output logic [1:0] mode
);
    localparam int DIV = REFERENCE_CLOCK / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int RW  = $clog2(RING_SECONDS + 1);
    localparam logic [3:0] HR_U_RST = (HOUR_MODE == 12) ? 4'd2 : 4'd0;
    localparam logic [1:0] HR_T_RST = (HOUR_MODE == 12) ? 2'd1 : 2'd0;

    typedef enum logic [1:0] {MODE_RUN = 2'd0, MODE_SET_TIME = 2'd1, MODE_SET_ALARM = 2'd2} mode_e;

    function automatic logic [5:0] inc_min(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    function automatic logic [4:0] inc_hr(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // 0-59 binary to {tens[2:0], units[3:0]}
    function automatic logic [6:0] to_bcd(input logic [5:0] v);
        logic [2:0] t;
        if (v >= 6'd50)      t = 3'd5;
        else if (v >= 6'd40) t = 3'd4;
        else if (v >= 6'd30) t = 3'd3;
        else if (v >= 6'd20) t = 3'd2;
        else if (v >= 6'd10) t = 3'd1;
        else                 t = 3'd0;
        return {t, 4'(v - 6'(t) * 6'd10)};
    endfunction

    // 0-23 hour to {pm, tens[1:0], units[3:0]} in the configured format
    function automatic logic [6:0] hr_bcd(input logic [4:0] h);
        logic [4:0] h12;
        logic       pm_v;
        logic [1:0] t;
        if (HOUR_MODE == 12) begin
            pm_v = (h >= 5'd12);
            if (h == 5'd0)       h12 = 5'd12;
            else if (h > 5'd12)  h12 = h - 5'd12;
            else                 h12 = h;
        end else begin
            pm_v = 1'b0;
            h12  = h;
        end
        if (h12 >= 5'd20)      t = 2'd2;
        else if (h12 >= 5'd10) t = 2'd1;
        else                   t = 2'd0;
        return {pm_v, t, 4'(h12 - 5'(t) * 5'd10)};
    endfunction

    logic [PW-1:0] presc_r;
    mode_e         mode_r, mode_nxt_s;
    logic [5:0]    sec_r, min_r, al_min_r, snz_min_r;
    logic [4:0]    hr_r, al_hr_r, snz_hr_r;
    logic          snz_act_r, ring_r;
    logic [RW-1:0] ring_cnt_r;
    logic          min_inc_d_r, hr_inc_d_r, snooze_d_r;

    logic          tick_s, qtick_s, roll_s, enter_set_s;
    logic          min_rise_s, hr_rise_s, snz_rise_s, al_match_s, snz_match_s;
    logic [5:0]    sec_adv_s, sec_n_s, min_n_s, al_min_n_s, snz_min_n_s, snz_tgt_min_s, d_min_s, d_sec_s;
    logic [4:0]    hr_n_s, al_hr_n_s, snz_hr_n_s, snz_tgt_hr_s, d_hr_s;
    logic [6:0]    snz_sum_s, sec_bcd_s, min_bcd_s, hr_bcd_s;
    logic          snz_act_n_s, ring_n_s;
    logic [RW-1:0] ring_cnt_n_s;

    assign tick_s      = (presc_r == PW'(DIV - 1));
    assign qtick_s     = tick_s && enable && (mode_r == MODE_RUN);
    assign roll_s      = qtick_s && (sec_r == 6'd59);
    assign min_rise_s  = min_inc && !min_inc_d_r;
    assign hr_rise_s   = hr_inc && !hr_inc_d_r;
    assign snz_rise_s  = snooze && !snooze_d_r;
    assign enter_set_s = (mode_nxt_s == MODE_SET_TIME) && (mode_r != MODE_SET_TIME);
    assign sec_n_s     = enter_set_s ? 6'd0 : sec_adv_s;
    assign al_match_s  = roll_s && alarm_en && (hr_n_s == al_hr_r) && (min_n_s == al_min_r);
    assign snz_match_s = roll_s && alarm_en && snz_act_r && (hr_n_s == snz_hr_r) && (min_n_s == snz_min_r);
    assign snz_sum_s   = {1'b0, min_r} + 7'(SNOOZE_MIN);
    assign alarm_out   = ring_r;
    assign mode        = mode_r;

    // Mode selection from the set levels; set_clock wins
    always_comb begin
        if (set_clock)      mode_nxt_s = MODE_SET_TIME;
        else if (set_alarm) mode_nxt_s = MODE_SET_ALARM;
        else                mode_nxt_s = MODE_RUN;
    end

    // Time advance and set-mode edits of the time and alarm registers
    always_comb begin
        sec_adv_s  = sec_r;
        min_n_s    = min_r;
        hr_n_s     = hr_r;
        al_min_n_s = al_min_r;
        al_hr_n_s  = al_hr_r;
        case (mode_r)
            MODE_RUN: begin
                if (qtick_s && (sec_r == 6'd59)) begin
                    sec_adv_s = 6'd0;
                    min_n_s   = inc_min(min_r);
                    hr_n_s    = (min_r == 6'd59) ? inc_hr(hr_r) : hr_r;
                end else if (qtick_s) begin
                    sec_adv_s = sec_r + 6'd1;
                end else begin
                    sec_adv_s = sec_r;
                end
            end
            MODE_SET_TIME: begin
                min_n_s = min_rise_s ? inc_min(min_r) : min_r;
                hr_n_s  = hr_rise_s ? inc_hr(hr_r) : hr_r;
            end
            MODE_SET_ALARM: begin
                al_min_n_s = min_rise_s ? inc_min(al_min_r) : al_min_r;
                al_hr_n_s  = hr_rise_s ? inc_hr(al_hr_r) : al_hr_r;
            end
            default: begin
                sec_adv_s = sec_r;
            end
        endcase
    end

    // Snooze target: current hh:mm plus the snooze delay, wrapping hour and day
    always_comb begin
        if (snz_sum_s >= 7'd60) begin
            snz_tgt_min_s = 6'(snz_sum_s - 7'd60);
            snz_tgt_hr_s  = inc_hr(hr_r);
        end else begin
            snz_tgt_min_s = snz_sum_s[5:0];
            snz_tgt_hr_s  = hr_r;
        end
    end

    // Ringing and snooze control, causes listed in priority order
    always_comb begin
        ring_n_s     = ring_r;
        ring_cnt_n_s = ring_cnt_r;
        snz_act_n_s  = snz_act_r;
        snz_min_n_s  = snz_min_r;
        snz_hr_n_s   = snz_hr_r;
        if (alarm_off || !alarm_en) begin
            ring_n_s    = 1'b0;
            snz_act_n_s = 1'b0;
        end else if (mode_nxt_s != MODE_RUN) begin
            ring_n_s = 1'b0;
        end else if (ring_r && snz_rise_s) begin
            ring_n_s    = 1'b0;
            snz_act_n_s = 1'b1;
            snz_min_n_s = snz_tgt_min_s;
            snz_hr_n_s  = snz_tgt_hr_s;
        end else if (al_match_s || snz_match_s) begin
            ring_n_s     = 1'b1;
            ring_cnt_n_s = '0;
            snz_act_n_s  = snz_match_s ? 1'b0 : snz_act_r;
        end else if (ring_r && qtick_s) begin
            ring_cnt_n_s = ring_cnt_r + 1'b1;
            ring_n_s     = (ring_cnt_n_s != RW'(RING_SECONDS));
        end else begin
            ring_n_s = ring_r;
        end
    end

    // Display source follows the mode being entered so digits and mode update together
    always_comb begin
        if (mode_nxt_s == MODE_SET_ALARM) begin
            d_sec_s = 6'd0;
            d_min_s = al_min_n_s;
            d_hr_s  = al_hr_n_s;
        end else begin
            d_sec_s = sec_n_s;
            d_min_s = min_n_s;
            d_hr_s  = hr_n_s;
        end
    end

    assign sec_bcd_s = to_bcd(d_sec_s);
    assign min_bcd_s = to_bcd(d_min_s);
    assign hr_bcd_s  = hr_bcd(d_hr_s);

    // State and registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r     <= '0;
            mode_r      <= MODE_RUN;
            sec_r       <= 6'd0;
            min_r       <= 6'd0;
            hr_r        <= 5'd0;
            al_min_r    <= 6'(ALARM_MIN_INIT);
            al_hr_r     <= 5'(ALARM_HR_INIT);
            snz_min_r   <= 6'd0;
            snz_hr_r    <= 5'd0;
            snz_act_r   <= 1'b0;
            ring_r      <= 1'b0;
            ring_cnt_r  <= '0;
            min_inc_d_r <= 1'b0;
            hr_inc_d_r  <= 1'b0;
            snooze_d_r  <= 1'b0;
            sec_u       <= 4'd0;
            sec_t       <= 3'd0;
            min_u       <= 4'd0;
            min_t       <= 3'd0;
            hr_u        <= HR_U_RST;
            hr_t        <= HR_T_RST;
            pm          <= 1'b0;
        end else begin
            presc_r     <= tick_s ? '0 : presc_r + 1'b1;
            mode_r      <= mode_nxt_s;
            sec_r       <= sec_n_s;
            min_r       <= min_n_s;
            hr_r        <= hr_n_s;
            al_min_r    <= al_min_n_s;
            al_hr_r     <= al_hr_n_s;
            snz_min_r   <= snz_min_n_s;
            snz_hr_r    <= snz_hr_n_s;
            snz_act_r   <= snz_act_n_s;
            ring_r      <= ring_n_s;
            ring_cnt_r  <= ring_cnt_n_s;
            min_inc_d_r <= min_inc;
            hr_inc_d_r  <= hr_inc;
            snooze_d_r  <= snooze;
            sec_u       <= sec_bcd_s[3:0];
            sec_t       <= sec_bcd_s[6:4];
            min_u       <= min_bcd_s[3:0];
            min_t       <= min_bcd_s[6:4];
            hr_u        <= hr_bcd_s[3:0];
            hr_t        <= hr_bcd_s[5:4];
            pm          <= hr_bcd_s[6];
        end
    end
endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core: a 24 h and a 12 h instance share all stimulus.
module tb_clock_alarm_core;
    logic clk = 1'b0, reset = 1'b0, enable = 1'b0, set_clock = 1'b0, set_alarm = 1'b0;
    logic min_inc = 1'b0, hr_inc = 1'b0, alarm_en = 1'b0, alarm_off = 1'b0, snooze = 1'b0;
    logic [3:0] a_sec_u, a_min_u, a_hr_u, b_sec_u, b_min_u, b_hr_u;
    logic [2:0] a_sec_t, a_min_t, b_sec_t, b_min_t;
    logic [1:0] a_hr_t, b_hr_t, a_mode, b_mode;
    logic a_pm, b_pm, a_alarm, b_alarm;
    int tests_run = 0, tests_failed = 0;
    int cyc;

    clock_alarm_core #(.REFERENCE_CLOCK(20), .TICK_HZ(2), .HOUR_MODE(24), .ALARM_HR_INIT(6),
        .ALARM_MIN_INIT(0), .SNOOZE_MIN(5), .RING_SECONDS(3)) u_dut24 (
        .clk(clk), .reset(reset), .enable(enable), .set_clock(set_clock), .set_alarm(set_alarm),
        .min_inc(min_inc), .hr_inc(hr_inc), .alarm_en(alarm_en), .alarm_off(alarm_off), .snooze(snooze),
        .sec_u(a_sec_u), .sec_t(a_sec_t), .min_u(a_min_u), .min_t(a_min_t), .hr_u(a_hr_u), .hr_t(a_hr_t),
        .pm(a_pm), .alarm_out(a_alarm), .mode(a_mode));

    clock_alarm_core #(.REFERENCE_CLOCK(20), .TICK_HZ(2), .HOUR_MODE(12), .ALARM_HR_INIT(6),
        .ALARM_MIN_INIT(0), .SNOOZE_MIN(5), .RING_SECONDS(3)) u_dut12 (
        .clk(clk), .reset(reset), .enable(enable), .set_clock(set_clock), .set_alarm(set_alarm),
        .min_inc(min_inc), .hr_inc(hr_inc), .alarm_en(alarm_en), .alarm_off(alarm_off), .snooze(snooze),
        .sec_u(b_sec_u), .sec_t(b_sec_t), .min_u(b_min_u), .min_t(b_min_t), .hr_u(b_hr_u), .hr_t(b_hr_t),
        .pm(b_pm), .alarm_out(b_alarm), .mode(b_mode));

    always #5 clk = ~clk;

    // Posedges since reset release; a tick lands on every tenth one
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int t24();
        return int'(a_hr_t) * 100000 + int'(a_hr_u) * 10000 + int'(a_min_t) * 1000
             + int'(a_min_u) * 100 + int'(a_sec_t) * 10 + int'(a_sec_u);
    endfunction

    function automatic int t12();
        return int'(b_hr_t) * 100000 + int'(b_hr_u) * 10000 + int'(b_min_t) * 1000
             + int'(b_min_u) * 100 + int'(b_sec_t) * 10 + int'(b_sec_u);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just after the n-th following tick edge
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (cyc % 10 != 0) @(negedge clk);
        end
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            min_inc = 1'b1; step(1);
            min_inc = 1'b0; step(1);
        end
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            hr_inc = 1'b1; step(1);
            hr_inc = 1'b0; step(1);
        end
    endtask

    initial begin
        step(3);
        check_eq("rst_t24", t24(), 0);
        check_eq("rst_t12", t12(), 120000);
        check_eq("rst_pm12", b_pm, 0);
        check_eq("rst_mode", a_mode, 0);
        check_eq("rst_alarm", a_alarm, 0);
        reset = 1'b1;
        enable = 1'b1;
        step(10);
        check_eq("first_tick", t24(), 1);
        enable = 1'b0;

        // 23:59:59 -> 00:00:00 (12 h: 11:59:59 pm -> 12:00:00 am)
        set_clock = 1'b1; step(1);
        pulse_hr(23); pulse_min(59);
        check_eq("preset_mode", a_mode, 1);
        check_eq("preset_t24", t24(), 235900);
        check_eq("preset_t12", t12(), 115900);
        check_eq("preset_pm12", b_pm, 1);
        set_clock = 1'b0; step(1);
        enable = 1'b1;
        run_ticks(59);
        check_eq("t24_235959", t24(), 235959);
        run_ticks(1);
        check_eq("wrap_day_t24", t24(), 0);
        check_eq("wrap_day_t12", t12(), 120000);
        check_eq("wrap_day_pm12", b_pm, 0);
        enable = 1'b0;

        // 12 h: 11:59:59 -> 12:00:00 pm, then 12:59:59 -> 01:00:00 pm
        set_clock = 1'b1; step(1);
        pulse_hr(11); pulse_min(59);
        set_clock = 1'b0; step(1);
        enable = 1'b1;
        run_ticks(59);
        check_eq("t12_115959", t12(), 115959);
        check_eq("t12_115959_pm", b_pm, 0);
        run_ticks(1);
        check_eq("noon_t12", t12(), 120000);
        check_eq("noon_pm12", b_pm, 1);
        check_eq("noon_t24", t24(), 120000);
        enable = 1'b0;
        set_clock = 1'b1; step(1);
        pulse_min(59);
        set_clock = 1'b0; step(1);
        enable = 1'b1;
        run_ticks(59);
        check_eq("t12_125959", t12(), 125959);
        run_ticks(1);
        check_eq("one_pm_t12", t12(), 10000);
        check_eq("one_pm_pm12", b_pm, 1);
        check_eq("one_pm_t24", t24(), 130000);
        enable = 1'b0;

        // Set mode: minutes wrap without hour carry; ticks frozen
        set_clock = 1'b1; step(1);
        pulse_hr(11); pulse_min(59);
        check_eq("set_0059", t24(), 5900);
        pulse_min(3);
        check_eq("set_min_wrap", t24(), 200);
        pulse_hr(1);
        check_eq("set_hr", t24(), 10200);
        check_eq("set_mode", a_mode, 1);
        enable = 1'b1; step(25);
        check_eq("set_frozen", t24(), 10200);
        check_eq("set_frozen_t12", t12(), 10200);
        enable = 1'b0;

        // Alarm at 06:00 rings, times out after three ticks
        pulse_hr(4); pulse_min(57);
        set_clock = 1'b0; alarm_en = 1'b1; step(1);
        enable = 1'b1;
        run_ticks(59);
        check_eq("pre_alarm_t24", t24(), 55959);
        check_eq("pre_alarm", a_alarm, 0);
        run_ticks(1);
        check_eq("alarm_rise", a_alarm, 1);
        check_eq("alarm_rise12", b_alarm, 1);
        run_ticks(2);
        check_eq("alarm_hold", a_alarm, 1);
        run_ticks(1);
        check_eq("alarm_timeout", a_alarm, 0);
        enable = 1'b0;

        // Snooze then alarm_off
        set_clock = 1'b1; step(1);
        pulse_hr(23); pulse_min(59);
        set_clock = 1'b0; step(1);
        enable = 1'b1;
        run_ticks(60);
        check_eq("ring_0600", a_alarm, 1);
        snooze = 1'b1; step(1);
        check_eq("snooze_stop", a_alarm, 0);
        snooze = 1'b0;
        run_ticks(299);
        check_eq("snz_060459", t24(), 60459);
        check_eq("snz_quiet", a_alarm, 0);
        run_ticks(1);
        check_eq("snz_ring", a_alarm, 1);
        alarm_off = 1'b1; step(1);
        check_eq("off_stop", a_alarm, 0);
        alarm_off = 1'b0;
        run_ticks(300);
        check_eq("t_061000", t24(), 61000);
        check_eq("no_ring_0610", a_alarm, 0);
        enable = 1'b0;

        // Priority, alarm edit, reset mid-ring
        set_clock = 1'b1; set_alarm = 1'b1; step(1);
        check_eq("both_mode", a_mode, 1);
        set_clock = 1'b0; step(1);
        check_eq("al_mode", a_mode, 2);
        check_eq("al_show", t24(), 60000);
        pulse_hr(1); pulse_min(10);
        check_eq("al_edit24", t24(), 71000);
        check_eq("al_edit12", t12(), 71000);
        set_alarm = 1'b0; set_clock = 1'b1; step(1);
        pulse_hr(1); pulse_min(59);
        set_clock = 1'b0; step(1);
        enable = 1'b1;
        run_ticks(60);
        check_eq("ring_0710", a_alarm, 1);
        reset = 1'b0;
        #1;
        check_eq("rst_ring24", a_alarm, 0);
        check_eq("rst_ring12", b_alarm, 0);
        step(2);
        reset = 1'b1;
        check_eq("rst2_t24", t24(), 0);
        set_alarm = 1'b1; step(1);
        check_eq("rst2_alarm", t24(), 60000);
        set_alarm = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/clock_alarm_core.md
Name: clock_alarm_core

Overview:
Parametrised BCD time-of-day clock with a programmable alarm, snooze and a selectable 12/24-hour format. It replaces the fixed 24 h clock datapath: one block holds time, alarm and snooze registers, the set-mode state machine and a tick prescaler. It drives six BCD digit buses into the existing BCD-to-7-segment decoders, plus an alarm output for a buzzer or LED.

Parameters:
REFERENCE_CLOCK, 50_000_000, clk frequency in Hz.
TICK_HZ, 1, time-advance rate; the prescaler divides by REFERENCE_CLOCK/TICK_HZ (integer, >=2).
HOUR_MODE, 24, 24 for 00–23 or 12 for 1–12 with the pm flag.
ALARM_HR_INIT, 6, alarm hour at reset (24 h value 0–23).
ALARM_MIN_INIT, 0, alarm minute at reset (0–59).
SNOOZE_MIN, 5, snooze delay in minutes (1–59).
RING_SECONDS, 60, ring auto-timeout in ticks (>=1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  time advance enable (gates the tick)
set_clock  in  1  level; high selects SET_TIME
set_alarm  in  1  level; high selects SET_ALARM
min_inc  in  1  increment minutes, rising-edge detected
hr_inc  in  1  increment hours, rising-edge detected
alarm_en  in  1  alarm armed
alarm_off  in  1  stop ringing and cancel snooze
snooze  in  1  stop ringing and re-arm after SNOOZE_MIN, rising-edge detected
sec_u  out  4  seconds units BCD
sec_t  out  3  seconds tens
min_u  out  4  minutes units
min_t  out  3  minutes tens
hr_u  out  4  hours units
hr_t  out  2  hours tens
pm  out  1  PM flag; always 0 when HOUR_MODE=24
alarm_out  out  1  ringing
mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM

Behaviour:
- Reset (async, reset=0):
  - Time is 00:00:00 (HOUR_MODE=12: 12:00:00, pm=0); alarm registers = INIT values; snooze inactive; alarm_out=0; mode=RUN; prescaler=0; edge detectors cleared.
- Prescaler:
  - One-cycle tick every REFERENCE_CLOCK/TICK_HZ clk cycles.
  - The prescaler runs regardless of mode; the tick is qualified by enable and mode==RUN.
- FSM, evaluated each clk:
  - set_clock=1 → SET_TIME; else set_alarm=1 → SET_ALARM; else RUN. set_clock has priority when both are high.
  - Entering SET_TIME clears seconds to 00.
  - Outputs are registered; mode updates one cycle after the inputs change.
- RUN:
  - On a qualified tick, seconds increment with BCD carry 59→00 into minutes, and minutes 59→00 into hours.
  - 24 h: hours wrap 23→00.
  - 12 h: 11:59:59→12:00:00 toggles pm; 12:59:59→01:00:00 leaves pm unchanged.
- SET_TIME / SET_ALARM:
  - Each min_inc rising edge adds 1 to the minutes of the selected register, wrapping 59→00 with no carry into hours.
  - Each hr_inc rising edge adds 1 to the hours: 24 h wraps 23→00; 12 h follows 11→12 (toggle pm), 12→1.
  - The display buses show the selected register. In SET_ALARM, seconds show 00 and pm shows the alarm's pm.
  - Time does not advance in either set mode.
- Alarm match:
  - Evaluated in RUN on the tick that makes seconds=00.
  - Condition: alarm_en=1 and hh:mm equals the alarm (or the snooze target while snooze is active).
  - On a match, alarm_out rises on the cycle after that tick; a snooze-target match clears snooze.
- Ringing ends on the first of:
  - alarm_off=1, which also clears snooze;
  - alarm_en=0;
  - snooze edge: snooze target = current hh:mm + SNOOZE_MIN, with wrap across hour and day, and snooze becomes active;
  - RING_SECONDS qualified ticks elapsed;
  - leaving RUN.
  - In every case alarm_out falls the cycle after the cause.
- Simultaneous events:
  - alarm_off beats snooze in the same cycle.
  - A snooze edge while not ringing is ignored.
  - A match while already ringing restarts the ring timer.
  - alarm_en=0 clears snooze.
- Reset asserted mid-ring or mid-set returns all state to reset values immediately.

Test Plan:
1. REFERENCE_CLOCK=20, TICK_HZ=2 (tick every 10 clk), HOUR_MODE=24. Release reset → digits 00:00:00; after 10 clk sec_u=1; preset 23:59:59 via set modes plus ticks, one tick later → 00:00:00.
2. HOUR_MODE=12, time at 11:59:59 pm=0, tick → 12:00:00 pm=1; preset 12:59:59, tick → 01:00:00 pm=1.
3. set_clock=1, 3 min_inc pulses from 00:59 → 00:02 (no hour carry), hr_inc → 01:02; mode=1; tick pulses do not change the time.
4. Alarm 06:00, alarm_en=1, time 05:59:59, tick → alarm_out=1 one cycle after; RING_SECONDS=3 ticks later → 0.
5. Ringing at 06:00, snooze edge → alarm_out=0; at 06:05:00 tick → alarm_out=1; alarm_off → 0 and no ring at 06:10.
6. set_clock and set_alarm both high → mode=1; reset pulse while ringing → alarm_out=0, alarm registers back to 06:00.
